// File: rtl/ddc_stream_arbiter.sv
// ddc_stream_arbiter: round-robin merge of NCH ddc sample streams into one
// 16-bit word stream (I word then Q word per sample), with sticky overrun flags.
module ddc_stream_arbiter #(
   parameter int NCH = 4,
   parameter int OSZ = 16,
   parameter int CSZ = 2
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [NCH-1:0]     ch_en,
   input  logic [NCH-1:0]     ch_valid,
   input  logic [NCH*OSZ-1:0] ch_i,
   input  logic [NCH*OSZ-1:0] ch_q,
   input  logic               ovf_clr,
   input  logic               out_ready,
   output logic               out_valid,
   output logic [OSZ-1:0]     out_data,
   output logic [CSZ-1:0]     out_chan,
   output logic               out_last,
   output logic [NCH-1:0]     ovf
);

   typedef enum logic [1:0] {IDLE, SEND_I, SEND_Q} state_t;

   state_t               state_q, state_d;
   logic [2*OSZ-1:0]     slot_q [NCH];
   logic [2*OSZ-1:0]     shadow_q, shadow_d;
   logic [NCH-1:0]       pend_q, pend_d;
   logic [NCH-1:0]       ovf_q, ovf_d;
   logic [CSZ-1:0]       rr_q, rr_d;
   logic [CSZ-1:0]       chan_q, chan_d;
   logic [NCH-1:0]       elig, cap, gnt, ovr, wr;
   logic [CSZ-1:0]       gidx, idx;
   logic                 found, grant_en, do_grant;

   // A disabled channel is never granted, even if its pend bit is still set.
   assign elig = pend_q & ch_en;
   assign cap  = ch_valid & ch_en;

   always_comb begin
      found = 1'b0;
      gidx  = '0;
      idx   = '0;
      for (int i = 1; i <= NCH; i++) begin
         idx = CSZ'((int'(rr_q) + i) % NCH);
         if (!found && elig[idx]) begin
            found = 1'b1;
            gidx  = idx;
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      grant_en = 1'b0;
      case (state_q)
         IDLE: begin
            grant_en = 1'b1;
            if (found) state_d = SEND_I;
         end
         SEND_I: begin
            if (out_ready) state_d = SEND_Q;
         end
         SEND_Q: begin
            if (out_ready) begin
               grant_en = 1'b1;
               state_d  = found ? SEND_I : IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign do_grant = grant_en & found;
   assign gnt      = do_grant ? (NCH'(1) << gidx) : '0;
   assign ovr      = cap & pend_q & ~gnt;
   // Slot is overwritten only when empty or being drained this cycle.
   assign wr       = cap & (~pend_q | gnt);

   always_comb begin
      pend_d   = (pend_q & ~gnt) | cap;
      pend_d   = pend_d & ch_en;
      ovf_d    = ovr | (ovf_q & {NCH{~ovf_clr}});
      rr_d     = do_grant ? gidx : rr_q;
      chan_d   = do_grant ? gidx : chan_q;
      shadow_d = do_grant ? slot_q[gidx] : shadow_q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         pend_q   <= '0;
         ovf_q    <= '0;
         rr_q     <= CSZ'(NCH - 1);
         chan_q   <= '0;
         shadow_q <= '0;
         for (int k = 0; k < NCH; k++) slot_q[k] <= '0;
      end else begin
         state_q  <= state_d;
         pend_q   <= pend_d;
         ovf_q    <= ovf_d;
         rr_q     <= rr_d;
         chan_q   <= chan_d;
         shadow_q <= shadow_d;
         for (int k = 0; k < NCH; k++) begin
            if (wr[k]) slot_q[k] <= {ch_i[k*OSZ +: OSZ], ch_q[k*OSZ +: OSZ]};
         end
      end
   end

   assign out_valid = (state_q != IDLE);
   assign out_last  = (state_q == SEND_Q);
   assign out_data  = (state_q == SEND_Q) ? shadow_q[OSZ-1:0] : shadow_q[2*OSZ-1:OSZ];
   assign out_chan  = chan_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_ddc_stream_arbiter.sv
// Directed bench for ddc_stream_arbiter: hand-computed word sequences, overrun,
// backpressure, channel disable and mid-transfer reset.
`timescale 1ns/1ps
module tb_ddc_stream_arbiter;
   localparam int NCH = 4;
   localparam int OSZ = 16;
   localparam int CSZ = 2;

   logic               clk = 1'b0;
   logic               reset_n;
   logic [NCH-1:0]     ch_en;
   logic [NCH-1:0]     ch_valid;
   logic [NCH*OSZ-1:0] ch_i;
   logic [NCH*OSZ-1:0] ch_q;
   logic               ovf_clr;
   logic               out_ready;
   logic               out_valid;
   logic [OSZ-1:0]     out_data;
   logic [CSZ-1:0]     out_chan;
   logic               out_last;
   logic [NCH-1:0]     ovf;

   int checks = 0;
   int errors = 0;

   ddc_stream_arbiter #(.NCH(NCH), .OSZ(OSZ), .CSZ(CSZ)) dut (
      .clk(clk), .reset_n(reset_n), .ch_en(ch_en), .ch_valid(ch_valid),
      .ch_i(ch_i), .ch_q(ch_q), .ovf_clr(ovf_clr), .out_ready(out_ready),
      .out_valid(out_valid), .out_data(out_data), .out_chan(out_chan),
      .out_last(out_last), .ovf(ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_sample(input int k, input logic [OSZ-1:0] i, input logic [OSZ-1:0] q);
      ch_i[k*OSZ +: OSZ] = i;
      ch_q[k*OSZ +: OSZ] = q;
      ch_valid[k] = 1'b1;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      tick();
   endtask

   task automatic chk_word(input string tag, input logic [OSZ-1:0] d, input logic [CSZ-1:0] c,
                           input logic l);
      chk({tag, "_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_data"},  32'(out_data),  32'(d));
      chk({tag, "_chan"},  32'(out_chan),  32'(c));
      chk({tag, "_last"},  32'(out_last),  32'(l));
   endtask

   initial begin
      reset_n = 1'b1; ch_en = '1; ch_valid = '0; ch_i = '0; ch_q = '0;
      ovf_clr = 1'b0; out_ready = 1'b1;
      #2;
      do_reset();
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_last",  32'(out_last),  32'd0);
      chk("rst_data",  32'(out_data),  32'd0);
      chk("rst_chan",  32'(out_chan),  32'd0);
      chk("rst_ovf",   32'(ovf),       32'd0);

      // single ch0 sample
      set_sample(0, 16'h1234, 16'hABCD);
      tick(); ch_valid = '0;
      chk("s0_pend_cycle_valid", 32'(out_valid), 32'd0);
      tick(); chk_word("s0_i", 16'h1234, 2'd0, 1'b0);
      tick(); chk_word("s0_q", 16'hABCD, 2'd0, 1'b1);
      tick(); chk("s0_idle", 32'(out_valid), 32'd0);

      // four channels at once, rr restarts from NCH-1
      do_reset();
      for (int k = 0; k < NCH; k++) set_sample(k, 16'h1000 + 16'(k), 16'h2000 + 16'(k));
      tick(); ch_valid = '0;
      for (int k = 0; k < NCH; k++) begin
         tick(); chk_word($sformatf("rr%0d_i", k), 16'h1000 + 16'(k), CSZ'(k), 1'b0);
         tick(); chk_word($sformatf("rr%0d_q", k), 16'h2000 + 16'(k), CSZ'(k), 1'b1);
      end
      tick(); chk("rr_idle", 32'(out_valid), 32'd0);
      chk("rr_ovf", 32'(ovf), 32'd0);

      // overrun on ch1 with ready low
      out_ready = 1'b0;
      set_sample(1, 16'hA001, 16'hB001);
      tick(); ch_valid = '0;
      tick();
      set_sample(1, 16'hA002, 16'hB002);
      tick();
      set_sample(1, 16'hA003, 16'hB003);
      tick(); ch_valid = '0;
      chk("ovr_flag", 32'(ovf), 32'h2);
      chk_word("ovr_a_i", 16'hA001, 2'd1, 1'b0);
      out_ready = 1'b1;
      tick(); chk_word("ovr_a_q", 16'hB001, 2'd1, 1'b1);
      tick(); chk_word("ovr_b_i", 16'hA002, 2'd1, 1'b0);
      tick(); chk_word("ovr_b_q", 16'hB002, 2'd1, 1'b1);
      tick(); chk("ovr_idle", 32'(out_valid), 32'd0);
      chk("ovr_sticky", 32'(ovf), 32'h2);
      ovf_clr = 1'b1;
      tick(); ovf_clr = 1'b0;
      chk("ovf_cleared", 32'(ovf), 32'd0);

      // backpressure stalls in SEND_I
      out_ready = 1'b0;
      set_sample(3, 16'hC3C3, 16'h3C3C);
      tick(); ch_valid = '0;
      tick();
      for (int n = 0; n < 5; n++) begin
         tick(); chk_word($sformatf("hold%0d", n), 16'hC3C3, 2'd3, 1'b0);
      end
      out_ready = 1'b1;
      tick(); chk_word("hold_q", 16'h3C3C, 2'd3, 1'b1);
      tick(); chk("hold_idle", 32'(out_valid), 32'd0);

      // disable ch2 while its sample is pending
      out_ready = 1'b0;
      set_sample(0, 16'h0F0F, 16'hF0F0);
      tick(); ch_valid = '0;
      tick();
      set_sample(2, 16'h2222, 16'h3333);
      tick();
      ch_en = 4'b1011;
      tick();
      tick(); ch_valid = '0;
      out_ready = 1'b1;
      chk_word("dis_c0_i", 16'h0F0F, 2'd0, 1'b0);
      tick(); chk_word("dis_c0_q", 16'hF0F0, 2'd0, 1'b1);
      tick(); chk("dis_idle", 32'(out_valid), 32'd0);
      chk("dis_ovf", 32'(ovf), 32'd0);
      ch_en = '1;
      tick(); tick(); chk("dis_no_ch2", 32'(out_valid), 32'd0);

      // reset during SEND_Q
      set_sample(0, 16'h5555, 16'h6666);
      tick(); ch_valid = '0;
      tick(); chk_word("mr_i", 16'h5555, 2'd0, 1'b0);
      tick(); chk_word("mr_q", 16'h6666, 2'd0, 1'b1);
      reset_n = 1'b0;
      #1 chk("mr_async_drop", 32'(out_valid), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      tick();
      chk("mr_after_rel", 32'(out_valid), 32'd0);
      set_sample(0, 16'h7777, 16'h8888);
      tick(); ch_valid = '0;
      tick(); chk_word("mr_restart_i", 16'h7777, 2'd0, 1'b0);
      tick(); chk_word("mr_restart_q", 16'h8888, 2'd0, 1'b1);
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
